// File: rtl/aes_pkg.sv
// Shared sizing constants and FSM state encoding for the AES-256 decryption scheduler.
package aes_pkg;
    localparam int NUM_ROUNDS = 14;
    localparam int NUM_RKEYS  = 15;
    localparam int KE_STEPS   = 7;
    localparam int BLK_W      = 128;
    localparam int KEY_W      = 256;
    localparam int RK_AW      = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEXP,
        ST_READY,
        ST_ROUND,
        ST_DONE
    } state_t;
endpackage

// File: rtl/aes_rkey_store.sv
// Round-key register file RK[1..15] in decryption order: two write ports, one read port.
module aes_rkey_store
    import aes_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_we_hi,
    input  logic [RK_AW-1:0] i_waddr_hi,
    input  logic [BLK_W-1:0] i_wdata_hi,
    input  logic             i_we_lo,
    input  logic [RK_AW-1:0] i_waddr_lo,
    input  logic [BLK_W-1:0] i_wdata_lo,
    input  logic [RK_AW-1:0] i_raddr,
    output logic [BLK_W-1:0] o_rdata
);
    logic [BLK_W-1:0] r_rk [1:NUM_RKEYS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 1; i <= NUM_RKEYS; i++) r_rk[i] <= '0;
        end else begin
            for (int i = 1; i <= NUM_RKEYS; i++) begin
                if (i_we_hi && (i_waddr_hi == RK_AW'(i)))
                    r_rk[i] <= i_wdata_hi;
                else if (i_we_lo && (i_waddr_lo == RK_AW'(i)))
                    r_rk[i] <= i_wdata_lo;
            end
        end
    end

    // Address 0 is not a valid entry and reads as zero.
    always_comb begin
        o_rdata = '0;
        for (int i = 1; i <= NUM_RKEYS; i++) begin
            if (i_raddr == RK_AW'(i)) o_rdata = r_rk[i];
        end
    end
endmodule

// File: rtl/aes_dec_scheduler.sv
// Sequences an external AES-256 key-expansion step and inverse-round unit to decrypt
// one 128-bit block at a time, with round keys held locally in decryption order.
module aes_dec_scheduler
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [KEY_W-1:0] key,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_data,
    output logic             busy,
    output logic [3:0]       ke_rc,
    output logic [KEY_W-1:0] ke_key,
    input  logic [KEY_W-1:0] ke_key_nxt,
    output logic [BLK_W-1:0] rd_state,
    output logic [BLK_W-1:0] rd_key,
    output logic             rd_last,
    input  logic [BLK_W-1:0] rd_result
);
    state_t           r_state, w_state_nxt;
    logic [KEY_W-1:0] r_kreg;
    logic [2:0]       r_step;
    logic [BLK_W-1:0] r_st;
    logic [3:0]       r_rnd;
    logic             r_out_valid;
    logic [BLK_W-1:0] r_out_data;

    logic             w_key_acc, w_in_acc, w_kexp_last, w_rnd_last;
    logic             w_we_hi, w_we_lo;
    logic [RK_AW-1:0] w_waddr_hi, w_waddr_lo, w_raddr;
    logic [BLK_W-1:0] w_wdata_hi, w_wdata_lo, w_rk;

    assign w_key_acc   = key_valid & key_ready;
    assign w_in_acc    = in_valid & in_ready;
    assign w_kexp_last = (r_step == 3'(KE_STEPS - 1));
    assign w_rnd_last  = (r_rnd == 4'(NUM_ROUNDS));
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;

    aes_rkey_store u_rkey_store (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_we_hi    (w_we_hi),
        .i_waddr_hi (w_waddr_hi),
        .i_wdata_hi (w_wdata_hi),
        .i_we_lo    (w_we_lo),
        .i_waddr_lo (w_waddr_lo),
        .i_wdata_lo (w_wdata_lo),
        .i_raddr    (w_raddr),
        .o_rdata    (w_rk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        key_ready   = 1'b0;
        in_ready    = 1'b0;
        busy        = 1'b0;
        ke_rc       = '0;
        ke_key      = '0;
        rd_state    = '0;
        rd_key      = '0;
        rd_last     = 1'b0;
        w_we_hi     = 1'b0;
        w_waddr_hi  = '0;
        w_wdata_hi  = '0;
        w_we_lo     = 1'b0;
        w_waddr_lo  = '0;
        w_wdata_lo  = '0;
        w_raddr     = 4'd1;
        case (r_state)
            ST_IDLE, ST_READY: begin
                key_ready = 1'b1;
                in_ready  = (r_state == ST_READY) && !key_valid;
                if (key_valid) begin
                    // The raw key is already encryption round keys 0 and 1.
                    w_state_nxt = ST_KEXP;
                    w_we_hi     = 1'b1;
                    w_waddr_hi  = 4'd15;
                    w_wdata_hi  = key[KEY_W-1:BLK_W];
                    w_we_lo     = 1'b1;
                    w_waddr_lo  = 4'd14;
                    w_wdata_lo  = key[BLK_W-1:0];
                end else if (in_valid && (r_state == ST_READY)) begin
                    w_state_nxt = ST_ROUND;
                end
            end
            ST_KEXP: begin
                busy       = 1'b1;
                ke_rc      = {1'b0, r_step};
                ke_key     = r_kreg;
                w_we_hi    = 1'b1;
                w_waddr_hi = 4'd13 - {r_step, 1'b0};
                w_wdata_hi = ke_key_nxt[KEY_W-1:BLK_W];
                // The last step's lower half would be a 16th round key AES-256 never uses.
                w_we_lo    = !w_kexp_last;
                w_waddr_lo = 4'd12 - {r_step, 1'b0};
                w_wdata_lo = ke_key_nxt[BLK_W-1:0];
                if (w_kexp_last) w_state_nxt = ST_READY;
            end
            ST_ROUND: begin
                busy     = 1'b1;
                w_raddr  = r_rnd + 4'd1;
                rd_state = r_st;
                rd_key   = w_rk;
                rd_last  = w_rnd_last;
                if (w_rnd_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                busy = 1'b1;
                if (out_ready) w_state_nxt = ST_READY;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kreg      <= '0;
            r_step      <= '0;
            r_st        <= '0;
            r_rnd       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_key_acc) begin
                r_kreg <= key;
                r_step <= '0;
            end else if (r_state == ST_KEXP) begin
                r_kreg <= ke_key_nxt;
                r_step <= r_step + 3'd1;
            end

            // Initial AddRoundKey uses RK[1], the last encryption round key.
            if (w_in_acc) begin
                r_st  <= in_data ^ w_rk;
                r_rnd <= 4'd1;
            end else if (r_state == ST_ROUND) begin
                r_st  <= rd_result;
                r_rnd <= r_rnd + 4'd1;
                if (w_rnd_last) begin
                    r_out_data  <= rd_result;
                    r_out_valid <= 1'b1;
                end
            end

            if ((r_state == ST_DONE) && out_ready) r_out_valid <= 1'b0;
        end
    end
endmodule
